// File: rtl/top_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : top_uart_tx
// Purpose  : Free-running UART transmitter. Repeats the message "Hello!\r\n"
//            on txd in 8N1 format, with IDLE_GAP idle-high clocks before
//            each message.
// Revision : 1.0 - initial release
// ============================================================================
module top_uart_tx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int IDLE_GAP  = 1000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    output logic txd
);

    // Clocks per bit; derived from the clock and bit rate, must be >= 2.
    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int BAUD_W   = $clog2(BAUD_DIV);
    localparam int GAP_W    = $clog2(IDLE_GAP + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(IDLE_GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t             state_q;
    logic               txd_q;
    logic [2:0]         byte_idx_q;
    logic [2:0]         bit_idx_q;
    logic [BAUD_W-1:0]  baud_cnt_q;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic [7:0]         shift_q;

    // Fixed message ROM: "Hello!\r\n".
    function automatic logic [7:0] rom_byte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'h48;
            3'd1:    b = 8'h65;
            3'd2:    b = 8'h6C;
            3'd3:    b = 8'h6C;
            3'd4:    b = 8'h6F;
            3'd5:    b = 8'h21;
            3'd6:    b = 8'h0D;
            default: b = 8'h0A;
        endcase
        return b;
    endfunction

    // Transmit FSM: txd is registered so it only changes on clock edges
    // (or on asynchronous reset assertion, where it is forced high).
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= S_IDLE;
            txd_q      <= 1'b1;
            byte_idx_q <= 3'd0;
            bit_idx_q  <= 3'd0;
            baud_cnt_q <= '0;
            gap_cnt_q  <= '0;
            shift_q    <= 8'h00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    txd_q <= 1'b1;
                    // Start bit begins on the edge that ends the last idle clock.
                    if (gap_cnt_q == GAP_LAST) begin
                        gap_cnt_q  <= '0;
                        shift_q    <= rom_byte(byte_idx_q);
                        baud_cnt_q <= '0;
                        txd_q      <= 1'b0;
                        state_q    <= S_START;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                S_START: begin
                    if (baud_cnt_q == BAUD_LAST) begin
                        baud_cnt_q <= '0;
                        bit_idx_q  <= 3'd0;
                        txd_q      <= shift_q[0];
                        state_q    <= S_DATA;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_cnt_q == BAUD_LAST) begin
                        baud_cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            txd_q     <= shift_q[bit_idx_q + 3'd1];
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (baud_cnt_q == BAUD_LAST) begin
                        baud_cnt_q <= '0;
                        if (byte_idx_q == 3'd7) begin
                            // Message complete: wrap and insert the idle gap.
                            byte_idx_q <= 3'd0;
                            gap_cnt_q  <= '0;
                            txd_q      <= 1'b1;
                            state_q    <= S_IDLE;
                        end else begin
                            // Next frame follows back-to-back.
                            byte_idx_q <= byte_idx_q + 3'd1;
                            shift_q    <= rom_byte(byte_idx_q + 3'd1);
                            txd_q      <= 1'b0;
                            state_q    <= S_START;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                default: begin
                    txd_q   <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign txd = txd_q;

endmodule
`default_nettype wire

// File: tb/tb_top_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_top_uart_tx
// Purpose  : Self-checking bench for top_uart_tx (small and default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_top_uart_tx;

    localparam int BD   = 16;          // small instance: 16/1
    localparam int GAP  = 20;
    localparam int FRM  = 10 * BD;     // 160 clocks per frame
    localparam int MSGL = 8 * FRM;     // 1280 clocks per message
    localparam int PER  = MSGL + GAP;  // repeat period after the first gap

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_s_n;
    logic rst_d_n;
    logic txd_s;
    logic txd_d;

    top_uart_tx #(.CLK_FREQ(16), .BAUD_RATE(1), .IDLE_GAP(GAP)) u_small (
        .sys_clk   (clk),
        .sys_rst_n (rst_s_n),
        .txd       (txd_s)
    );

    top_uart_tx u_dflt (
        .sys_clk   (clk),
        .sys_rst_n (rst_d_n),
        .txd       (txd_d)
    );

    int n_vec = 0;
    int n_bad = 0;
    int k;                       // rising edges since reset release (small DUT)
    logic samp [0:1599];         // captured txd per k, first 1600 edges
    logic [7:0] msg [8] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h21, 8'h0D, 8'h0A};

    typedef struct {
        int   kk;
        logic exp;
    } vec_t;

    // Reference: expected line level after k edges, from the frame rules.
    function automatic logic model_txd(input int kk);
        int pos, f, b;
        if (kk < GAP) return 1'b1;
        pos = (kk - GAP) % PER;
        if (pos >= MSGL) return 1'b1;
        f = pos / FRM;
        b = (pos % FRM) / BD;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return msg[f][b-1];
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: txd=%b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_s(input int n, input string tag);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            k++;
            if (k < 1600) samp[k] = txd_s;
            check_bit($sformatf("%s_k%0d", tag, k), txd_s, model_txd(k));
        end
    endtask

    // Decode frame j of the captured samples at mid-bit points.
    function automatic logic [7:0] decode(input int j);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = samp[GAP + FRM*j + BD*(i+1) + BD/2];
        return b;
    endfunction

    task automatic async_reset(input string tag);
        #2;
        rst_s_n = 1'b0;
        #1;
        check_bit({tag, "_async"}, txd_s, 1'b1);
        @(negedge clk);
        check_bit({tag, "_held"}, txd_s, 1'b1);
        rst_s_n = 1'b1;
        k = 0;
    endtask

    initial begin
        vec_t tbl [11];
        int   tr [$];
        int   e;
        int   n;
        logic prev;
        int   pos [7] = '{0, 4, 5, 7, 8, 9, 10};

        tbl = '{'{28, 1'b0}, '{44, 1'b0}, '{60, 1'b0}, '{76, 1'b0}, '{92, 1'b1},
                '{108, 1'b0}, '{124, 1'b0}, '{140, 1'b1}, '{156, 1'b0}, '{172, 1'b1},
                '{188, 1'b0}};

        rst_s_n = 1'b0;
        rst_d_n = 1'b0;
        k = 0;

        // Reset held: line idle high.
        repeat (5) begin
            @(negedge clk);
            check_bit("reset_hold", txd_s, 1'b1);
        end

        // Release and follow two messages against the reference.
        rst_s_n = 1'b1;
        run_s(GAP + PER + 200, "run");

        check_bit("gap_last_idle", samp[GAP-1], 1'b1);
        check_bit("gap_fall", samp[GAP], 1'b0);
        for (int i = 0; i < 11; i++)
            check_bit($sformatf("frame0_bit%0d", i), samp[tbl[i].kk], tbl[i].exp);
        for (int j = 0; j < 8; j++)
            check_int($sformatf("msg_byte%0d", j), int'(decode(j)), int'(msg[j]));
        check_int("msg_repeat", int'(decode(8 + 0) & 8'h00) + int'(decode_rep()), 8'h48);

        // Reset in the middle of D0 of byte 3 (line low there).
        run_s(GAP + PER + 3*FRM + BD + BD/2 - k, "to_b3");
        check_bit("pre_reset_b3", txd_s, 1'b0);
        async_reset("mid_b3");
        run_s(200, "after_b3");
        check_int("restart_byte", int'(decode(0)), 8'h48);

        // Randomly placed resets.
        repeat (4) begin
            n = $urandom_range(1, 1400);
            run_s(n, "rnd");
            async_reset("rnd_rst");
            run_s($urandom_range(30, 300), "rnd_post");
        end

        // Default parameters: gap, bit widths and frame length.
        check_bit("dflt_reset", txd_d, 1'b1);
        rst_d_n = 1'b1;
        e = 0;
        prev = 1'b1;
        while (tr.size() < 7 && e < 8000) begin
            @(posedge clk);
            @(negedge clk);
            e++;
            if (txd_d !== prev) begin
                tr.push_back(e);
                prev = txd_d;
            end
        end
        check_int("dflt_edges_seen", tr.size(), 7);
        if (tr.size() == 7) begin
            for (int i = 0; i < 7; i++)
                check_int($sformatf("dflt_edge%0d", i), tr[i], 1000 + 434*pos[i]);
            check_int("dflt_bit_width", tr[2] - tr[1], 434);
            check_int("dflt_frame", tr[6] - tr[0], 4340);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // First byte of the second message, captured after the inter-message gap.
    function automatic logic [7:0] decode_rep();
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = samp[GAP + PER + BD*(i+1) + BD/2];
        return b;
    endfunction

endmodule
`default_nettype wire
